// File: rtl/lo_sched.sv
// LO sequencer: timebase counter, Gray window and enable, queued (shift, dwell) configs switched on period boundaries.
// Latency: start acts on the next edge; config switches take effect on the edge ending a boundary cycle; cfg_err lags its offer by one cycle.
// Backpressure: cfg_ready drops while the config FIFO is full; a pop in the same cycle does not reopen it until the next cycle.
module lo_sched #(
  parameter int CW    = 17,
  parameter int DW    = 12,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [3:0]    cfg_shift,
  input  logic [DW-1:0] cfg_dwell,
  output logic          cfg_err,
  input  logic          start,
  input  logic          stop,
  output logic [7:0]    lo_gray_clk,
  output logic          lo_rstb,
  output logic          busy,
  output logic          done,
  output logic          switch_pulse,
  output logic [3:0]    cur_shift,
  output logic [DW-1:0] periods_left
);

  // DEPTH is a power of two >= 2; pointers carry one extra wrap bit.
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state;
  logic [CW-1:0] tc;

  logic [3:0]    mem_shift [DEPTH];
  logic [DW-1:0] mem_dwell [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          shift_legal;
  logic          push;
  logic          pop;
  logic [3:0]    head_shift;
  logic [DW-1:0] head_dwell;
  logic [DW-1:0] head_periods;

  logic [CW:0]   span;
  logic [CW-1:0] bnd_mask;
  logic [CW-1:0] gray;
  logic          bnd;
  logic          last_period;

  assign fifo_cnt     = wr_ptr - rd_ptr;
  assign fifo_empty   = (fifo_cnt == '0);
  assign cfg_ready    = (fifo_cnt < (AW+1)'(DEPTH));
  assign shift_legal  = (cfg_shift <= 4'd8);
  assign push         = cfg_valid & cfg_ready & shift_legal;
  assign head_shift   = mem_shift[rd_ptr[AW-1:0]];
  assign head_dwell   = mem_dwell[rd_ptr[AW-1:0]];
  assign head_periods = (head_dwell == '0) ? DW'(1) : head_dwell;

  // Boundary: the low cur_shift+9 bits of tc are all ones (last clock of an LO period).
  assign span        = (CW+1)'(1) << (5'(cur_shift) + 5'd9);
  assign bnd_mask    = CW'(span - (CW+1)'(1));
  assign bnd         = ((tc & bnd_mask) == bnd_mask);
  assign last_period = (periods_left == DW'(1));

  // Pop on start from IDLE, or when a RUN config expires at a boundary with another queued.
  assign pop = !fifo_empty &&
               ((state == IDLE && start) ||
                (state == RUN && !stop && bnd && last_period));

  assign gray        = tc ^ (tc >> 1);
  assign lo_gray_clk = 8'(gray >> cur_shift);
  assign lo_rstb     = (state != IDLE);
  assign busy        = (state != IDLE);

  // Config storage; entries need no reset since the pointers gate their use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_shift[wr_ptr[AW-1:0]] <= cfg_shift;
      mem_dwell[wr_ptr[AW-1:0]] <= cfg_dwell;
    end
  end

  // FIFO pointers; push and pop in the same cycle are both applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Illegal shift offers are flagged one cycle later and never enqueued.
  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_valid & ~shift_legal;
  end

  // Sequencer: timebase, period counting and boundary-aligned config switching.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tc           <= '0;
      cur_shift    <= '0;
      periods_left <= '0;
      done         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      done         <= 1'b0;
      switch_pulse <= 1'b0;
      case (state)
        IDLE: begin
          tc <= '0;
          if (start && !fifo_empty) begin
            state        <= RUN;
            cur_shift    <= head_shift;
            periods_left <= head_periods;
          end
        end
        RUN: begin
          if (bnd && (stop || (last_period && fifo_empty))) begin
            state        <= IDLE;
            tc           <= '0;
            periods_left <= '0;
            done         <= 1'b1;
          end else if (bnd && last_period) begin
            tc           <= '0;
            cur_shift    <= head_shift;
            periods_left <= head_periods;
            switch_pulse <= 1'b1;
          end else begin
            tc <= tc + CW'(1);
            if (bnd)  periods_left <= periods_left - DW'(1);
            if (stop) state <= STOPPING;
          end
        end
        STOPPING: begin
          if (bnd) begin
            state        <= IDLE;
            tc           <= '0;
            periods_left <= '0;
            done         <= 1'b1;
          end else begin
            tc <= tc + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lo_sched.sv
// Directed bench for lo_sched: reset, single config, switch, cfg_err, full FIFO, stop and mid-run reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Every loop is cycle-bounded so the run always reaches the summary line.
module tb_lo_sched;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_shift;
  logic [11:0] cfg_dwell;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic [7:0]  lo_gray_clk;
  logic        lo_rstb;
  logic        busy;
  logic        done;
  logic        switch_pulse;
  logic [3:0]  cur_shift;
  logic [11:0] periods_left;

  int n_checks = 0;
  int n_pass   = 0;

  lo_sched #(.CW(17), .DW(12), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_shift(cfg_shift),
    .cfg_dwell(cfg_dwell), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .lo_gray_clk(lo_gray_clk), .lo_rstb(lo_rstb), .busy(busy), .done(done),
    .switch_pulse(switch_pulse), .cur_shift(cur_shift), .periods_left(periods_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference window: 8-bit slice of gray(t) starting at bit sh.
  function automatic logic [7:0] win(input int t, input int sh);
    logic [16:0] tcv;
    logic [16:0] g;
    tcv = 17'(t);
    g   = tcv ^ (tcv >> 1);
    return 8'(g >> sh);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cfg(input logic [3:0] sh, input logic [11:0] dw);
    cfg_valid = 1'b1;
    cfg_shift = sh;
    cfg_dwell = dw;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (lo_gray_clk !== 8'h00) $display("FAIL rst_gray got %h want 00", lo_gray_clk); else n_pass++;
    n_checks++; if (lo_rstb !== 1'b0) $display("FAIL rst_rstb got %b want 0", lo_rstb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({done, switch_pulse, cfg_err} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {done, switch_pulse, cfg_err}); else n_pass++;
    n_checks++; if (cur_shift !== 4'd0) $display("FAIL rst_cur_shift got %0d want 0", cur_shift); else n_pass++;
    n_checks++; if (periods_left !== 12'd0) $display("FAIL rst_periods got %0d want 0", periods_left); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", cfg_ready); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  // (shift 0, dwell 2): 1024 busy cycles, bit 7 of the window toggles every 256 clocks.
  task automatic test_single_cfg();
    int busy_cnt = 0, done_cnt = 0, done_at = -1, win_err = 0, bad_gap = 0;
    int tog[$];
    logic prev7;
    logic [11:0] pl0 = '0, pl_mid = '0;
    logic rstb0 = 1'b0, rstb_last = 1'b0, rstb_after = 1'b1;
    push_cfg(4'd0, 12'd2);
    pulse_start();
    prev7 = lo_gray_clk[7];
    for (int k = 0; k < 1100; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = k; end
      if (k > 0 && lo_gray_clk[7] !== prev7) tog.push_back(k);
      prev7 = lo_gray_clk[7];
      if (lo_gray_clk !== ((k < 1024) ? win(k, 0) : 8'h00)) win_err++;
      if (k == 0) begin pl0 = periods_left; rstb0 = lo_rstb; end
      if (k == 512) pl_mid = periods_left;
      if (k == 1023) rstb_last = lo_rstb;
      if (k == 1024) rstb_after = lo_rstb;
      step();
    end
    for (int i = 1; i < tog.size(); i++) if (tog[i] - tog[i-1] != 256) bad_gap++;
    n_checks++; if (pl0 !== 12'd2 || rstb0 !== 1'b1) $display("FAIL single_start got pl=%0d rstb=%b want 2 1", pl0, rstb0); else n_pass++;
    n_checks++; if (busy_cnt != 1024) $display("FAIL single_busy_len got %0d want 1024", busy_cnt); else n_pass++;
    n_checks++; if (done_cnt != 1 || done_at != 1024) $display("FAIL single_done got cnt=%0d at=%0d want 1 at 1024", done_cnt, done_at); else n_pass++;
    n_checks++; if (tog.size() != 4 || tog[0] != 128 || bad_gap != 0) $display("FAIL single_toggle got n=%0d first=%0d badgap=%0d want 4 128 0", tog.size(), (tog.size() > 0) ? tog[0] : -1, bad_gap); else n_pass++;
    n_checks++; if (win_err != 0) $display("FAIL single_window got %0d bad cycles want 0", win_err); else n_pass++;
    n_checks++; if (pl_mid !== 12'd1) $display("FAIL single_decrement got %0d want 1", pl_mid); else n_pass++;
    n_checks++; if (rstb_last !== 1'b1 || rstb_after !== 1'b0) $display("FAIL single_rstb_fall got %b%b want 10", rstb_last, rstb_after); else n_pass++;
  endtask

  // (0,1) then (1,1): switch at 512, done at 1536, window never jumps by more than one bit.
  task automatic test_switch();
    int sp_cnt = 0, sp_at = -1, done_at = -1, win_err = 0, multi = 0;
    logic [7:0] prev_w;
    logic [3:0] cs_sw = '0;
    logic b_last = 1'b0, b_after = 1'b1;
    logic [7:0] exp_w;
    push_cfg(4'd0, 12'd1);
    push_cfg(4'd1, 12'd1);
    pulse_start();
    prev_w = lo_gray_clk;
    for (int k = 0; k < 1600; k++) begin
      if (switch_pulse) begin sp_cnt++; sp_at = k; cs_sw = cur_shift; end
      if (done && done_at < 0) done_at = k;
      if ($countones(prev_w ^ lo_gray_clk) > 1) multi++;
      prev_w = lo_gray_clk;
      if (k < 512)       exp_w = win(k, 0);
      else if (k < 1536) exp_w = win(k - 512, 1);
      else               exp_w = 8'h00;
      if (lo_gray_clk !== exp_w) win_err++;
      if (k == 1535) b_last = busy;
      if (k == 1536) b_after = busy;
      step();
    end
    n_checks++; if (sp_cnt != 1 || sp_at != 512) $display("FAIL switch_pulse got cnt=%0d at=%0d want 1 at 512", sp_cnt, sp_at); else n_pass++;
    n_checks++; if (cs_sw !== 4'd1) $display("FAIL switch_shift got %0d want 1", cs_sw); else n_pass++;
    n_checks++; if (done_at != 1536) $display("FAIL switch_done got %0d want 1536", done_at); else n_pass++;
    n_checks++; if (multi != 0) $display("FAIL switch_single_bit got %0d multi-bit steps want 0", multi); else n_pass++;
    n_checks++; if (win_err != 0) $display("FAIL switch_window got %0d bad cycles want 0", win_err); else n_pass++;
    n_checks++; if (b_last !== 1'b1 || b_after !== 1'b0) $display("FAIL switch_busy_end got %b%b want 10", b_last, b_after); else n_pass++;
  endtask

  // Illegal shift 9: cfg_err one cycle later, nothing enqueued (start then does nothing).
  task automatic test_cfg_err();
    cfg_valid = 1'b1;
    cfg_shift = 4'd9;
    cfg_dwell = 12'd3;
    #1;
    n_checks++; if (cfg_err !== 1'b0) $display("FAIL err_no_comb got %b want 0", cfg_err); else n_pass++;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) $display("FAIL err_pulse got %b want 1", cfg_err); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL err_ready got %b want 1", cfg_ready); else n_pass++;
    step();
    n_checks++; if (cfg_err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", cfg_err); else n_pass++;
    pulse_start();
    n_checks++; if (busy !== 1'b0) $display("FAIL err_not_enqueued busy got %b want 0", busy); else n_pass++;
  endtask

  // Three pushes: third refused; dwell 0 runs as 1; shift 8 accepted and switched to.
  task automatic test_fifo_full();
    int sp_at = -1;
    logic [3:0] cs_sw = '0;
    logic [11:0] pl_sw = '0;
    push_cfg(4'd3, 12'd0);
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL full_ready1 got %b want 1", cfg_ready); else n_pass++;
    push_cfg(4'd8, 12'd6);
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL full_ready2 got %b want 0", cfg_ready); else n_pass++;
    push_cfg(4'd4, 12'd7);
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL full_ready3 got %b want 0", cfg_ready); else n_pass++;
    pulse_start();
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL full_reopen got %b want 1", cfg_ready); else n_pass++;
    n_checks++; if (cur_shift !== 4'd3 || periods_left !== 12'd1) $display("FAIL full_head got shift=%0d pl=%0d want 3 1", cur_shift, periods_left); else n_pass++;
    for (int k = 0; k < 4100; k++) begin
      if (switch_pulse && sp_at < 0) begin sp_at = k; cs_sw = cur_shift; pl_sw = periods_left; end
      step();
    end
    n_checks++; if (sp_at != 4096) $display("FAIL full_switch_at got %0d want 4096", sp_at); else n_pass++;
    n_checks++; if (cs_sw !== 4'd8 || pl_sw !== 12'd6) $display("FAIL full_second got shift=%0d pl=%0d want 8 6", cs_sw, pl_sw); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1 || busy !== 1'b1) $display("FAIL full_drained got ready=%b busy=%b want 1 1", cfg_ready, busy); else n_pass++;
    do_reset();
  endtask

  // Graceful stop keeps the queued config; a mid-run reset flushes everything.
  task automatic test_stop_and_reset();
    int done_cnt = 0, done_at = -1, sp_cnt = 0;
    logic b511 = 1'b0, b512 = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_idle got busy=%b want 0", busy); else n_pass++;
    push_cfg(4'd0, 12'd4);
    push_cfg(4'd2, 12'd3);
    pulse_start();
    for (int k = 0; k < 600; k++) begin
      if (done) begin done_cnt++; done_at = k; end
      if (switch_pulse) sp_cnt++;
      if (k == 511) b511 = busy;
      if (k == 512) b512 = busy;
      stop = (k == 100);
      step();
    end
    stop = 1'b0;
    n_checks++; if (done_cnt != 1 || done_at != 512) $display("FAIL stop_done got cnt=%0d at=%0d want 1 at 512", done_cnt, done_at); else n_pass++;
    n_checks++; if (b511 !== 1'b1 || b512 !== 1'b0) $display("FAIL stop_busy got %b%b want 10", b511, b512); else n_pass++;
    n_checks++; if (sp_cnt != 0) $display("FAIL stop_no_switch got %0d want 0", sp_cnt); else n_pass++;
    pulse_start();
    n_checks++; if (cur_shift !== 4'd2 || periods_left !== 12'd3) $display("FAIL stop_retained got shift=%0d pl=%0d want 2 3", cur_shift, periods_left); else n_pass++;
    push_cfg(4'd1, 12'd1);
    for (int k = 1; k < 300; k++) step();
    n_checks++; if (busy !== 1'b1) $display("FAIL rstrun_busy got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    step();
    n_checks++; if (lo_rstb !== 1'b0 || lo_gray_clk !== 8'h00 || busy !== 1'b0) $display("FAIL rstrun_outputs got rstb=%b gray=%h busy=%b want 0 00 0", lo_rstb, lo_gray_clk, busy); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rstrun_ready got %b want 1", cfg_ready); else n_pass++;
    reset = 1'b0;
    pulse_start();
    n_checks++; if (busy !== 1'b0) $display("FAIL rstrun_flushed got busy=%b want 0", busy); else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_shift = '0;
    cfg_dwell = '0;
    start     = 1'b0;
    stop      = 1'b0;
    #1;
    test_reset();
    test_single_cfg();
    test_switch();
    test_cfg_err();
    test_fifo_full();
    test_stop_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
